// File: rtl/data_mem_responder_if.sv
// Load/store port between the processor memory stage (master) and the
// data memory responder (slave): valid/ready request and response channels.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering load/store requests over a
// valid/ready handshake, with a fixed number of wait states before the
// array access, byte-lane stores and misaligned/out-of-range error reporting.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic                    cap_write;
    logic [31:0]             cap_addr;
    logic [31:0]             cap_wdata;
    logic [3:0]              cap_be;
    logic [31:0]             rdata;
    logic                    error;
    logic                    accept;
    logic                    access;
    logic                    done;
    logic                    cap_err;
    logic                    do_store;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             mem [DEPTH];

    // Misaligned byte address, or word index beyond the array (no aliasing).
    function automatic logic addr_error(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= (32'd1 << ADDR_WIDTH));
    endfunction

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return merged;
    endfunction

    assign idx      = cap_addr[ADDR_WIDTH+1:2];
    assign cap_err  = addr_error(cap_addr);
    // Gated by rst so an edge coinciding with reset can never commit a store.
    assign do_store = access && cap_write && !cap_err && !rst;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_error = error;

    // Next-state and per-edge strobes for accept, array access and handshake.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter and registered response fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 4'd0;
            rdata <= 32'd0;
            error <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                error <= cap_err;
                rdata <= (!cap_write && !cap_err) ? mem[idx] : 32'd0;
            end else if (done) begin
                error <= 1'b0;
                rdata <= 32'd0;
            end
        end
    end

    // Request capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_be    <= bus.req_be;
        end
    end

    // Storage array; never cleared by reset.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[idx] <= merge_lanes(mem[idx], cap_wdata, cap_be);
        end
    end
endmodule
